// File: rtl/transpose_pass_engine_if.sv
// -----------------------------------------------------------------------------
// transpose_pass_engine_if
// Bundles the scheduler handshake and the PE-array lane bus of the transpose
// pass engine.
//   master : scheduler side. Drives start/opcode/length and observes status
//            and lane controls.
//   slave  : engine side. Samples the start request and drives lane controls,
//            the read address and status.
// Signals:
//   start_transpose            one-cycle start pulse
//   Instruction_code_transpose opcode (8'h03 = transpose)
//   num_iterations             pass length N, 1..256
//   lane_en/first/last         16-lane skewed enable wavefront
//   rd_addr                    lane-0 operand read address
//   done_transpose             completed-lane count, 0..16
//   busy, err_opcode, start_overrun  status
// -----------------------------------------------------------------------------
interface transpose_pass_engine_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start_transpose;
    logic [7:0]            Instruction_code_transpose;
    logic [8:0]            num_iterations;
    logic [15:0]           lane_en;
    logic [15:0]           lane_first;
    logic [15:0]           lane_last;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [4:0]            done_transpose;
    logic                  busy;
    logic                  err_opcode;
    logic                  start_overrun;

    modport master (
        output start_transpose, Instruction_code_transpose, num_iterations,
        input  lane_en, lane_first, lane_last, rd_addr,
        input  done_transpose, busy, err_opcode, start_overrun
    );

    modport slave (
        input  start_transpose, Instruction_code_transpose, num_iterations,
        output lane_en, lane_first, lane_last, rd_addr,
        output done_transpose, busy, err_opcode, start_overrun
    );
endinterface

// File: rtl/transpose_pass_engine.sv
// -----------------------------------------------------------------------------
// transpose_pass_engine
// Accepts one transpose pass from the scheduler and drives a 16-lane skewed
// enable wavefront into the transpose PE columns. Lane 0 is generated from the
// iteration counter; lanes 1..15 are a registered shift chain of lane 0, so
// every lane sees exactly N enabled cycles, one cycle after its neighbour.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  transpose_pass_engine_if slave modport (handshake + lane bus)
// -----------------------------------------------------------------------------
module transpose_pass_engine #(
    parameter int ADDR_WIDTH = 10
) (
    input logic                    clk,
    input logic                    rst,
    transpose_pass_engine_if.slave bus
);
    localparam logic [7:0] OPC_TRANSPOSE = 8'h03;
    localparam int         LANES         = 16;
    // The chain needs 15 extra cycles to carry the last lane-0 iteration to lane 15.
    localparam logic [3:0] DRAIN_LAST    = 4'd14;
    localparam logic [4:0] DONE_MAX      = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [8:0]       r_n;
    logic [8:0]       r_k;
    logic [3:0]       r_drain_cnt;
    logic [LANES-1:1] r_en_chain;
    logic [LANES-1:1] r_first_chain;
    logic [LANES-1:1] r_last_chain;
    logic [4:0]       r_done;
    logic             r_err;
    logic             r_overrun;

    logic             w_can_start;
    logic             w_busy;
    logic             w_accept;
    logic             w_reject;
    logic             w_k_last;
    logic             w_lane0_en;
    logic             w_lane0_first;
    logic             w_lane0_last;
    logic [LANES-1:0] w_lane_last;

    // HOLD behaves exactly like IDLE for start sampling, which allows
    // back-to-back passes with no idle cycle in between.
    assign w_can_start   = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign w_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_accept      = w_can_start && bus.start_transpose &&
                           (bus.Instruction_code_transpose == OPC_TRANSPOSE) &&
                           (bus.num_iterations != 9'd0);
    assign w_reject      = w_can_start && bus.start_transpose && !w_accept;

    // 9-bit compare against N-1 lets N = 256 run k = 0..255 without wrapping.
    assign w_k_last      = (r_k == (r_n - 9'd1));
    assign w_lane0_en    = (r_state == S_RUN);
    assign w_lane0_first = w_lane0_en && (r_k == 9'd0);
    assign w_lane0_last  = w_lane0_en && w_k_last;
    assign w_lane_last   = {r_last_chain, w_lane0_last};

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end else if (w_reject) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_k_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = S_HOLD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n           <= 9'd0;
            r_k           <= 9'd0;
            r_drain_cnt   <= 4'd0;
            r_en_chain    <= '0;
            r_first_chain <= '0;
            r_last_chain  <= '0;
            r_done        <= 5'd0;
            r_err         <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_n <= bus.num_iterations;
            end

            // k only advances in RUN; it rests at 0 elsewhere, so an accepted
            // start always begins the pass at k = 0.
            r_k         <= w_lane0_en ? (r_k + 9'd1) : 9'd0;
            r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + 4'd1) : 4'd0;

            r_en_chain    <= {r_en_chain[LANES-2:1],    w_lane0_en};
            r_first_chain <= {r_first_chain[LANES-2:1], w_lane0_first};
            r_last_chain  <= {r_last_chain[LANES-2:1],  w_lane0_last};

            // A start (accepted or rejected) clears the count so the scheduler
            // never sees a stale 16 in its first wait cycle.
            if (w_accept || w_reject) begin
                r_done <= 5'd0;
            end else if ((|w_lane_last) && (r_done != DONE_MAX)) begin
                r_done <= r_done + 5'd1;
            end

            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end

            r_overrun <= bus.start_transpose && w_busy;
        end
    end

    assign bus.lane_en        = {r_en_chain,    w_lane0_en};
    assign bus.lane_first     = {r_first_chain, w_lane0_first};
    assign bus.lane_last      = w_lane_last;
    assign bus.rd_addr        = w_lane0_en ? ADDR_WIDTH'(r_k) : '0;
    assign bus.done_transpose = r_done;
    assign bus.busy           = w_busy;
    assign bus.err_opcode     = r_err;
    assign bus.start_overrun  = r_overrun;
endmodule
